// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store front-end: request sizes and FSM states.
package mem_access_unit_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    LD     = 2'b01,
    RMW_RD = 2'b10,
    ST     = 2'b11
  } mau_state_e;

  // Natural alignment check; reserved size is reported as misaligned too.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = offset[0];
      SZ_WORD: is_misaligned = (offset != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: load extraction/extension and sub-word store merge.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rd_word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] wdata,
  output logic [31:0] ext_data,
  output logic [31:0] merged_word
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = 8'h00;
    case (offset)
      2'd0: byte_lane = rd_word[31:24];
      2'd1: byte_lane = rd_word[23:16];
      2'd2: byte_lane = rd_word[15:8];
      2'd3: byte_lane = rd_word[7:0];
      default: byte_lane = 8'h00;
    endcase
    half_lane = offset[1] ? rd_word[15:0] : rd_word[31:16];

    case (size)
      SZ_BYTE: ext_data = {{24{sign_ext & byte_lane[7]}}, byte_lane};
      SZ_HALF: ext_data = {{16{sign_ext & half_lane[15]}}, half_lane};
      default: ext_data = rd_word;
    endcase
  end

  // Byte lane gi holds bits [8gi+7:8gi], i.e. big-endian byte offset 3-gi.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam logic [1:0] LANE_OFF = 2'(3 - gi);
      localparam int         HALF_SRC = ((gi % 2) == 1) ? 8 : 0;

      logic       lane_wr;
      logic [7:0] lane_data;

      always_comb begin
        lane_wr   = 1'b0;
        lane_data = wdata[8*gi +: 8];
        case (size)
          SZ_BYTE: begin
            lane_wr   = (offset == LANE_OFF);
            lane_data = wdata[7:0];
          end
          SZ_HALF: begin
            lane_wr   = (offset[1] == LANE_OFF[1]);
            lane_data = wdata[HALF_SRC +: 8];
          end
          SZ_WORD: lane_wr = 1'b1;
          default: lane_wr = 1'b0;
        endcase
      end

      assign merged_word[8*gi +: 8] = lane_wr ? lane_data : rd_word[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-wide big-endian data memory; sub-word stores
// are done as read-modify-write, bad requests are answered without touching memory.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 8096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  mau_state_e  state_reg, state_next;
  logic [31:0] addr_reg;
  logic [1:0]  size_reg;
  logic        signed_reg;
  logic [31:0] wbuf_reg;
  logic        resp_valid_reg, resp_err_reg;
  logic [31:0] resp_rdata_reg;

  logic        accept;
  logic        range_err;
  logic        req_err;
  logic [31:0] ext_data;
  logic [31:0] merged_word;

  // The last byte of the addressed word must lie inside the memory.
  assign range_err = ({req_addr[31:2], 2'b11} >= 32'(MEM_BYTES));
  assign req_err   = range_err | is_misaligned(req_size, req_addr[1:0]);
  assign accept    = req_valid & req_ready;

  mem_lane_align u_align (
    .rd_word     (mem_rdata),
    .offset      (addr_reg[1:0]),
    .size        (size_reg),
    .sign_ext    (signed_reg),
    .wdata       (wbuf_reg),
    .ext_data    (ext_data),
    .merged_word (merged_word)
  );

  // Memory drive is decoded from state alone, so reset silences it at once.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    mem_en     = 1'b0;
    mem_wr     = 1'b0;
    mem_addr   = 32'h0;
    mem_wdata  = 32'h0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !req_err) begin
          if (!req_wr)
            state_next = LD;
          else if (req_size == SZ_WORD)
            state_next = ST;
          else
            state_next = RMW_RD;
        end
      end
      LD: begin
        mem_en     = 1'b1;
        mem_addr   = {addr_reg[31:2], 2'b00};
        state_next = IDLE;
      end
      RMW_RD: begin
        mem_en     = 1'b1;
        mem_addr   = {addr_reg[31:2], 2'b00};
        state_next = ST;
      end
      ST: begin
        mem_en     = 1'b1;
        mem_wr     = 1'b1;
        mem_addr   = {addr_reg[31:2], 2'b00};
        mem_wdata  = wbuf_reg;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= 32'h0;
      size_reg       <= SZ_BYTE;
      signed_reg     <= 1'b0;
      wbuf_reg       <= 32'h0;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'h0;
    end else begin
      state_reg      <= state_next;
      resp_valid_reg <= 1'b0;
      resp_err_reg   <= 1'b0;
      resp_rdata_reg <= 32'h0;

      if (accept) begin
        addr_reg   <= req_addr;
        size_reg   <= req_size;
        signed_reg <= req_signed;
        wbuf_reg   <= req_wdata;
        if (req_err) begin
          resp_valid_reg <= 1'b1;
          resp_err_reg   <= 1'b1;
        end
      end

      case (state_reg)
        LD: begin
          resp_valid_reg <= 1'b1;
          resp_rdata_reg <= ext_data;
        end
        RMW_RD: wbuf_reg <= merged_word;
        ST:     resp_valid_reg <= 1'b1;
        default: ;
      endcase
    end
  end

  assign resp_valid = resp_valid_reg;
  assign resp_err   = resp_err_reg;
  assign resp_rdata = resp_rdata_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a behavioural word-wide big-endian memory.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_en;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_access_unit #(.MEM_BYTES(8096)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wr     (req_wr),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write at the edge closing a write cycle.
  logic [31:0] mem_model [0:2047];
  int          en_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] last_wdata = 32'h0;
  logic        wr_pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] pend_data = 32'h0;

  assign mem_rdata = (mem_en && !mem_wr) ? mem_model[mem_addr[12:2]] : 32'h0;

  always @(negedge clk) begin
    if (mem_en) en_cnt++;
    if (mem_en && mem_wr) begin
      wr_cnt++;
      last_wdata = mem_wdata;
      wr_pend    = 1'b1;
      pend_addr  = mem_addr;
      pend_data  = mem_wdata;
    end
  end

  always @(posedge clk) begin
    if (wr_pend) begin
      if (rst_n) mem_model[pend_addr[12:2]] = pend_data;
      wr_pend = 1'b0;
    end
  end

  // Issues one request and waits (bounded) for its response pulse.
  task automatic do_req(input logic wr, input logic [1:0] size, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int ens, output int wrs);
    int en0, wr0;
    en0 = en_cnt;
    wr0 = wr_cnt;
    req_valid = 1'b1; req_wr = wr; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wdata;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL req_ready_at_issue addr=%h: got %b expected 1", addr, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_wr = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    lat = 99; rdata = 32'hDEAD_BEEF; err = 1'bx;
    for (int n = 1; n <= 8; n++) begin
      if (resp_valid === 1'b1) begin
        lat = n; rdata = resp_rdata; err = resp_err;
        break;
      end
      @(posedge clk); #1;
    end
    ens = en_cnt - en0;
    wrs = wr_cnt - wr0;
    $display("txn wr=%0d size=%0d sgn=%0d addr=%h wdata=%h -> lat=%0d rdata=%h err=%b mem_en=%0d mem_wr=%0d",
             wr, size, sgn, addr, wdata, lat, rdata, err, ens, wrs);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata} !== 66'h0) begin
      errors++; $display("FAIL reset_mem_outputs: got en=%b wr=%b addr=%h wdata=%h expected all 0", mem_en, mem_wr, mem_addr, mem_wdata);
    end
    checks++;
    if ({resp_valid, resp_err, resp_rdata} !== 34'h0) begin
      errors++; $display("FAIL reset_resp: got valid=%b err=%b rdata=%h expected all 0", resp_valid, resp_err, resp_rdata);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_word;
    int lat, ens, wrs; logic [31:0] rd; logic err;
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, lat, rd, err, ens, wrs);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_store_latency: got %0d expected 2", lat); end
    checks++; if (wrs !== 1 || ens !== 1) begin errors++; $display("FAIL word_store_pulses: got en=%0d wr=%0d expected 1/1", ens, wrs); end
    checks++; if (last_wdata !== 32'h11223344) begin errors++; $display("FAIL word_store_wdata: got %h expected 11223344", last_wdata); end
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL word_store_resp: got err=%b rdata=%h expected 0/00000000", err, rd); end
    do_req(1'b0, SZ_WORD, 1'b1, 32'h10, 32'h0, lat, rd, err, ens, wrs);
    checks++; if (lat !== 2) begin errors++; $display("FAIL word_load_latency: got %0d expected 2", lat); end
    checks++; if (rd !== 32'h11223344 || err !== 1'b0) begin errors++; $display("FAIL word_load_data: got %h err=%b expected 11223344 err=0", rd, err); end
    checks++; if (ens !== 1 || wrs !== 0) begin errors++; $display("FAIL word_load_pulses: got en=%0d wr=%0d expected 1/0", ens, wrs); end
  endtask

  task automatic test_sub_loads;
    int lat, ens, wrs; logic [31:0] rd; logic err;
    logic [31:0] t_addr [6] = '{32'h13, 32'h13, 32'h10, 32'h10, 32'h12, 32'h10};
    logic [1:0]  t_size [6] = '{SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_BYTE, SZ_HALF};
    logic        t_sgn  [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [31:0] t_exp  [6] = '{32'hFFFFFFF4, 32'h000000F4, 32'h00000011, 32'h00000011, 32'h00000033, 32'h00001122};
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h112233F4, lat, rd, err, ens, wrs);
    for (int i = 0; i < 6; i++) begin
      do_req(1'b0, t_size[i], t_sgn[i], t_addr[i], 32'h0, lat, rd, err, ens, wrs);
      checks++;
      if (rd !== t_exp[i] || err !== 1'b0 || lat !== 2 || ens !== 1) begin
        errors++; $display("FAIL sub_load_%0d: got rdata=%h err=%b lat=%0d en=%0d expected %h 0 2 1", i, rd, err, lat, ens, t_exp[i]);
      end
    end
    do_req(1'b1, SZ_WORD, 1'b0, 32'h10, 32'h11223344, lat, rd, err, ens, wrs);
  endtask

  task automatic test_sub_stores;
    int lat, ens, wrs; logic [31:0] rd; logic err;
    do_req(1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hFFFFFFAB, lat, rd, err, ens, wrs);
    checks++; if (lat !== 3) begin errors++; $display("FAIL byte_store_latency: got %0d expected 3", lat); end
    checks++; if (ens !== 2 || wrs !== 1) begin errors++; $display("FAIL byte_store_pulses: got en=%0d wr=%0d expected 2/1", ens, wrs); end
    checks++; if (last_wdata !== 32'h11AB3344) begin errors++; $display("FAIL byte_store_merge: got %h expected 11AB3344", last_wdata); end
    checks++; if (err !== 1'b0 || rd !== 32'h0) begin errors++; $display("FAIL byte_store_resp: got err=%b rdata=%h expected 0/00000000", err, rd); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, err, ens, wrs);
    checks++; if (rd !== 32'h11AB3344) begin errors++; $display("FAIL byte_store_readback: got %h expected 11AB3344", rd); end
    do_req(1'b1, SZ_HALF, 1'b0, 32'h12, 32'h1234BEEF, lat, rd, err, ens, wrs);
    checks++; if (lat !== 3 || last_wdata !== 32'h11ABBEEF) begin errors++; $display("FAIL half_store: got lat=%0d wdata=%h expected 3 11ABBEEF", lat, last_wdata); end
    do_req(1'b0, SZ_HALF, 1'b1, 32'h12, 32'h0, lat, rd, err, ens, wrs);
    checks++; if (rd !== 32'hFFFFBEEF) begin errors++; $display("FAIL half_load_signed: got %h expected FFFFBEEF", rd); end
    do_req(1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, lat, rd, err, ens, wrs);
    checks++; if (rd !== 32'h0000BEEF) begin errors++; $display("FAIL half_load_unsigned: got %h expected 0000BEEF", rd); end
  endtask

  task automatic test_errors;
    int lat, ens, wrs; logic [31:0] rd; logic err;
    logic        t_wr   [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [1:0]  t_size [6] = '{SZ_HALF, SZ_WORD, SZ_WORD, SZ_RSVD, SZ_BYTE, SZ_WORD};
    logic [31:0] t_addr [6] = '{32'h11, 32'h1E, 32'h1FA0, 32'h10, 32'h1FA1, 32'h12};
    for (int i = 0; i < 6; i++) begin
      do_req(t_wr[i], t_size[i], 1'b0, t_addr[i], 32'h5A5A5A5A, lat, rd, err, ens, wrs);
      checks++;
      if (lat !== 1 || err !== 1'b1 || rd !== 32'h0 || ens !== 0) begin
        errors++; $display("FAIL err_case_%0d: got lat=%0d err=%b rdata=%h en=%0d expected 1 1 00000000 0", i, lat, err, rd, ens);
      end
    end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0 || resp_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got valid=%b err=%b expected 0/0", resp_valid, resp_err); end
    do_req(1'b1, SZ_WORD, 1'b0, 32'h1F9C, 32'hCAFEF00D, lat, rd, err, ens, wrs);
    checks++; if (lat !== 2 || err !== 1'b0 || wrs !== 1) begin errors++; $display("FAIL top_word_store: got lat=%0d err=%b wr=%0d expected 2 0 1", lat, err, wrs); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h1F9C, 32'h0, lat, rd, err, ens, wrs);
    checks++; if (rd !== 32'hCAFEF00D || err !== 1'b0) begin errors++; $display("FAIL top_word_load: got %h err=%b expected CAFEF00D 0", rd, err); end
    do_req(1'b0, SZ_BYTE, 1'b1, 32'h1F9F, 32'h0, lat, rd, err, ens, wrs);
    checks++; if (rd !== 32'h0000000D || err !== 1'b0) begin errors++; $display("FAIL top_byte_load: got %h err=%b expected 0000000D 0", rd, err); end
  endtask

  task automatic test_back_to_back;
    int lat, ens, wrs; logic [31:0] rd; logic err;
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, err, ens, wrs);
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_ready_with_resp: got ready=%b valid=%b expected 1/1", req_ready, resp_valid); end
    do_req(1'b0, SZ_HALF, 1'b0, 32'h1F9C, 32'h0, lat, rd, err, ens, wrs);
    checks++; if (lat !== 2 || rd !== 32'h0000CAFE) begin errors++; $display("FAIL b2b_second_load: got lat=%0d rdata=%h expected 2 0000CAFE", lat, rd); end
    @(posedge clk); #1;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width: got %b expected 0", resp_valid); end
  endtask

  task automatic test_reset_midflight;
    int lat, ens, wrs, wr0; logic [31:0] rd; logic err; logic seen;
    req_valid = 1'b1; req_wr = 1'b1; req_size = SZ_BYTE; req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0; req_wr = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
    checks++; if (mem_en !== 1'b1 || mem_wr !== 1'b0) begin errors++; $display("FAIL rmw_read_cycle: got en=%b wr=%b expected 1/0", mem_en, mem_wr); end
    wr0 = wr_cnt;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_en !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 32'h0) begin errors++; $display("FAIL reset_async_drop: got en=%b wr=%b addr=%h expected 0 0 0", mem_en, mem_wr, mem_addr); end
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      if (resp_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL reset_no_resp: got resp_valid pulse, expected none"); end
    checks++; if (wr_cnt !== wr0) begin errors++; $display("FAIL reset_no_write: got %0d writes expected 0", wr_cnt - wr0); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
    do_req(1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, lat, rd, err, ens, wrs);
    checks++; if (rd !== 32'h11ABBEEF || err !== 1'b0) begin errors++; $display("FAIL reset_word_intact: got %h err=%b expected 11ABBEEF 0", rd, err); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem_model[i] = 32'h0;
    test_reset();
    test_word();
    test_sub_loads();
    test_sub_stores();
    test_errors();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
